connect_ser_des: RTL and testbench



---
 rtl/connect_ser_des.sv | 65 ++++++
 tb/tb_connect_ser_des.sv | 132 +++++++++++++
 2 files changed

// File: rtl/connect_ser_des.sv
// Loopback SERDES link check: an 8-bit word is serialized MSB-first onto a
// one-bit internal link, then reassembled onto out_comp 8 clocks later.
module connect_ser_des (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] in_comp,
  output logic [7:0] out_comp
);

  typedef enum logic {IDLE, RECV} rx_state_t;

  logic [2:0] tx_cnt;
  logic [7:0] tx_sh;
  logic       ser_data;
  logic       ser_sof;

  rx_state_t  rx_state;
  logic [6:0] rx_sh;
  logic [2:0] rx_cnt;

  // ser_data is the MSB of the shift register, so it is already registered.
  assign ser_data = tx_sh[7];

  // Serializer: capture on tx_cnt == 0, shift out MSB-first otherwise
  always_ff @(posedge clk) begin
    if (nreset) begin
      tx_cnt  <= 3'd0;
      tx_sh   <= 8'd0;
      ser_sof <= 1'b0;
    end else begin
      tx_cnt  <= tx_cnt + 3'd1;
      ser_sof <= (tx_cnt == 3'd0);
      if (tx_cnt == 3'd0) begin
        tx_sh <= in_comp;
      end else begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
    end
  end

  // Deserializer: ser_sof marks bit 7 and re-aligns the bit count.
  // Only the low 7 received bits need storing; bit 0 of the word is taken
  // straight from the link on the completing edge.
  always_ff @(posedge clk) begin
    if (nreset) begin
      rx_state <= IDLE;
      rx_sh    <= 7'd0;
      rx_cnt   <= 3'd0;
      out_comp <= 8'd0;
    end else if (ser_sof) begin
      rx_state <= RECV;
      rx_sh    <= {6'd0, ser_data};
      rx_cnt   <= 3'd1;
    end else if (rx_state == RECV) begin
      rx_sh <= {rx_sh[5:0], ser_data};
      if (rx_cnt == 3'd7) begin
        out_comp <= {rx_sh, ser_data};
        rx_cnt   <= 3'd0;
      end else begin
        rx_cnt <= rx_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_connect_ser_des.sv
// Directed bench for connect_ser_des: reset, link bit order, streaming,
// mid-frame input change and mid-frame reset.
module tb_connect_ser_des;

  logic       clk;
  logic       nreset;
  logic [7:0] in_comp;
  logic [7:0] out_comp;

  int checks = 0;
  int errors = 0;

  connect_ser_des dut (
    .clk      (clk),
    .nreset   (nreset),
    .in_comp  (in_comp),
    .out_comp (out_comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_word;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    nreset = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    nreset = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    nreset  = 1'b1;
    in_comp = 8'hA5;

    // Reset held with a non-zero input: output must stay zero
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_hold", out_comp, 8'h00);
    end

    // Single word after release; watch the link bit by bit
    nreset  = 1'b0;
    in_comp = 8'hF0;
    w = 8'hF0;
    step();  // E0
    check("sof_at_e0", {7'd0, dut.ser_sof}, 8'h01);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("link_bit%0d", 7 - k), {7'd0, dut.ser_data}, {7'd0, w[7-k]});
      check("out_before_e8", out_comp, 8'h00);
      step();
    end
    check("single_word_e8", out_comp, 8'hF0);

    // Mid-frame input change is ignored until the next capture edge
    do_reset(1);
    in_comp = 8'h80;
    step();  // E0
    for (int i = 0; i < 3; i++) step();
    in_comp = 8'hFF;
    for (int i = 0; i < 4; i++) step();
    check("midchg_hold", out_comp, 8'h00);
    step();  // E8
    check("midchg_e8", out_comp, 8'h80);
    for (int i = 0; i < 7; i++) step();
    check("midchg_hold2", out_comp, 8'h80);
    step();  // E16
    check("midchg_e16", out_comp, 8'hFF);

    // Reset at E16+4 discards the partial frame
    in_comp = 8'h3C;
    for (int i = 0; i < 3; i++) step();
    nreset = 1'b1;
    step();
    check("midrst_clear", out_comp, 8'h00);
    nreset  = 1'b0;
    in_comp = 8'h5A;
    step();  // new E0
    in_comp = 8'h00;
    for (int i = 0; i < 7; i++) begin
      check("midrst_no_partial", out_comp, 8'h00);
      step();
    end
    step();  // new E8
    check("midrst_first_word", out_comp, 8'h5A);

    // Streaming table: each word is captured on one edge and appears 8 edges later
    vecs[0]  = '{8'hF0, 8'h00};
    vecs[1]  = '{8'hFE, 8'hF0};
    vecs[2]  = '{8'h80, 8'hFE};
    vecs[3]  = '{8'hFF, 8'h80};
    vecs[4]  = '{8'hC2, 8'hFF};
    vecs[5]  = '{8'hFE, 8'hC2};
    vecs[6]  = '{8'h00, 8'hFE};
    vecs[7]  = '{8'hFF, 8'h00};
    vecs[8]  = '{8'h01, 8'hFF};
    vecs[9]  = '{8'h80, 8'h01};
    vecs[10] = '{8'h00, 8'h80};

    do_reset(2);
    for (int i = 0; i < 11; i++) begin
      in_comp = vecs[i].in_word;
      step();  // capture edge
      check($sformatf("stream_%0d", i), out_comp, vecs[i].exp_out);
      in_comp = ~vecs[i].in_word;
      for (int j = 0; j < 7; j++) step();
      check($sformatf("stream_hold_%0d", i), out_comp, vecs[i].exp_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
